// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// req/ack handshakes, ack timeout into a sticky FAULT, and a retired-instruction counter.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [14:0]      cw,
  input  logic             zero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [1:0]       pc_sel,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  // state  | meaning
  // IDLE   | stopped at an instruction boundary
  // FETCH  | imem_req held until imem_ack, IR loaded on ack
  // DECODE | one cycle for cw to settle
  // EXEC   | branch resolution, PC update
  // MEM    | dmem_req held until dmem_ack
  // WB     | register-file write
  // FAULT  | memory ack timeout, sticky until rst
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              complete;

  logic       rw, ps, mw;
  logic [1:0] md, bs;
  logic       taken, waiting, ack_w;

  assign rw = cw[14];
  assign md = cw[13:12];
  assign bs = cw[11:10];
  assign ps = cw[9];
  assign mw = cw[8];

  assign taken   = (bs == 2'b01) ? (zero ^ ps) : (bs != 2'b00);
  assign waiting = (cur == FETCH) || (cur == MEM);
  assign ack_w   = (cur == FETCH) ? imem_ack : dmem_ack;
  assign state   = cur;

  always_comb begin
    nxt      = cur;
    complete = 1'b0;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    pc_sel   = 2'b00;
    fault    = 1'b0;
    case (cur)
      IDLE: if (run) nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          nxt     = DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt = FAULT;
        end
      end
      DECODE: nxt = EXEC;
      EXEC: begin
        if (taken) begin
          pc_load = 1'b1;
          pc_sel  = bs;
        end else begin
          pc_inc = 1'b1;
        end
        if (mw || (md == 2'b01)) nxt = MEM;
        else if (rw)             nxt = WB;
        else                     complete = 1'b1;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mw;
        // ack on the last wait cycle still beats the timeout
        if (dmem_ack) begin
          if (md == 2'b01) nxt = WB;
          else             complete = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt = FAULT;
        end
      end
      WB: begin
        rf_we    = 1'b1;
        complete = 1'b1;
      end
      FAULT: fault = 1'b1;
      default: nxt = IDLE;
    endcase
    if (complete) nxt = run ? FETCH : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= IDLE;
      wait_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      cur <= nxt;
      if (complete) retire_cnt <= retire_cnt + CNT_W'(1);
      // counter is zero whenever not mid-wait, so every FETCH/MEM entry starts at 0
      if (waiting && !ack_w && (nxt == cur)) wait_cnt <= wait_cnt + 1'b1;
      else                                   wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: memory responders push expected
// per-instruction outcomes at fetch; a monitor pops and compares at each retire.
module tb_multicycle_sequencer;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst, run, zero, imem_ack, dmem_ack;
  logic [14:0] cw;
  logic imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc, pc_load, fault;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [CNT_W-1:0] retire_cnt;

  multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .cw(cw), .zero(zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_inc(pc_inc), .pc_load(pc_load), .pc_sel(pc_sel),
    .fault(fault), .state(state), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] cw;
    logic        zero;
    int          ilat;
    int          dlat;
    bit          retire;
    int          n_inc;
    int          n_load;
    logic [1:0]  sel;
    int          n_rfwe;
    int          n_dreq;
    int          n_dwe;
    int          cycles;
  } vec_t;

  vec_t prog[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;
  bit force_iack = 0;
  bit force_dack = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [14:0] c, input logic z, input int il, input int dl,
                              input int inc, input int ld, input logic [1:0] s, input int rf,
                              input int dr, input int dw, input int cy);
    vec_t v;
    v.cw = c; v.zero = z; v.ilat = il; v.dlat = dl; v.retire = 1'b1;
    v.n_inc = inc; v.n_load = ld; v.sel = s; v.n_rfwe = rf;
    v.n_dreq = dr; v.n_dwe = dw; v.cycles = cy;
    return v;
  endfunction

  // instruction memory: ack after ilat request cycles, then hand over the next cw
  int icnt = 0;
  int dcnt = 0;
  int cur_dlat = 0;
  always @(posedge clk) begin
    #1;
    if (imem_req) begin
      icnt++;
      if (prog.size() > 0 && icnt >= prog[0].ilat) begin
        imem_ack = 1'b1;
        cw       = prog[0].cw;
        zero     = prog[0].zero;
        cur_dlat = prog[0].dlat;
        if (prog[0].retire) sb.push_back(prog[0]);
        void'(prog.pop_front());
      end else begin
        imem_ack = 1'b0;
      end
    end else begin
      icnt     = 0;
      imem_ack = force_iack;
    end
  end

  // data memory: dlat==0 means never acknowledge
  always @(posedge clk) begin
    #1;
    if (dmem_req) begin
      dcnt++;
      dmem_ack = (cur_dlat > 0) && (dcnt == cur_dlat);
    end else begin
      dcnt     = 0;
      dmem_ack = force_dack;
    end
  end

  int m_open = 0, m_cyc = 0, m_inc = 0, m_load = 0, m_rfwe = 0, m_dreq = 0, m_dwe = 0;
  logic [1:0] m_sel = 2'b00;
  logic [CNT_W-1:0] m_last = '0;
  vec_t e;

  always @(negedge clk) begin
    if (rst) begin
      m_open = 0;
      m_last = '0;
    end else begin
      if (retire_cnt != m_last) begin
        check("retire_step", retire_cnt, m_last + 1);
        if (sb.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          e = sb.pop_front();
          check("instr_open", m_open, 1);
          check("cycles", m_cyc, e.cycles);
          check("pc_inc_cnt", m_inc, e.n_inc);
          check("pc_load_cnt", m_load, e.n_load);
          check("pc_sel", m_sel, e.sel);
          check("rf_we_cnt", m_rfwe, e.n_rfwe);
          check("dmem_req_cnt", m_dreq, e.n_dreq);
          check("dmem_we_cnt", m_dwe, e.n_dwe);
        end
        m_last = retire_cnt;
        m_open = 0;
      end
      if (ir_load) begin
        m_open = 1; m_cyc = 1; m_inc = 0; m_load = 0; m_rfwe = 0;
        m_dreq = 0; m_dwe = 0; m_sel = 2'b00;
      end else if (m_open != 0) begin
        m_cyc++;
        m_inc  += int'(pc_inc);
        m_load += int'(pc_load);
        m_rfwe += int'(rf_we);
        m_dreq += int'(dmem_req);
        m_dwe  += int'(dmem_we);
        m_sel  |= pc_sel;
      end
    end
  end

  logic [CNT_W-1:0] saved_cnt;
  vec_t tv;

  initial begin
    rst = 1'b1; run = 1'b0; cw = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_state", state, 0);
    check("reset_outputs", {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc, pc_load, pc_sel, fault}, 0);
    check("reset_retire", retire_cnt, 0);

    force_iack = 1'b1;
    @(negedge clk);
    force_iack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored", state, 0);

    prog.push_back(mk(15'b100000000010000, 1'b0, 1,  0, 1, 0, 2'b00, 1,  0,  0,  4));
    prog.push_back(mk(15'b000010000000101, 1'b1, 1,  0, 0, 1, 2'b01, 0,  0,  0,  3));
    prog.push_back(mk(15'b000011000000101, 1'b1, 1,  0, 1, 0, 2'b00, 0,  0,  0,  3));
    prog.push_back(mk(15'b101000000000000, 1'b0, 1,  4, 1, 0, 2'b00, 1,  4,  0,  8));
    prog.push_back(mk(15'b000100000000000, 1'b0, 1,  0, 0, 1, 2'b10, 0,  0,  0,  3));
    prog.push_back(mk(15'b000010000000101, 1'b0, 1,  0, 1, 0, 2'b00, 0,  0,  0,  3));
    prog.push_back(mk(15'b000011000000101, 1'b0, 1,  0, 0, 1, 2'b01, 0,  0,  0,  3));
    prog.push_back(mk(15'b000000100000000, 1'b0, 1,  1, 1, 0, 2'b00, 0,  1,  1,  4));
    prog.push_back(mk(15'b000000000000000, 1'b0, 1,  0, 1, 0, 2'b00, 0,  0,  0,  3));
    prog.push_back(mk(15'b100000000010000, 1'b0, 3,  0, 1, 0, 2'b00, 1,  0,  0,  4));
    prog.push_back(mk(15'b101000000000000, 1'b0, 1, 16, 1, 0, 2'b00, 1, 16,  0, 20));
    prog.push_back(mk(15'b000000100000000, 1'b0, 1, 16, 1, 0, 2'b00, 0, 16, 16, 19));
    prog.push_back(mk(15'b100000100000000, 1'b0, 1,  1, 1, 0, 2'b00, 0,  1,  1,  4));
    prog.push_back(mk(15'b000110000000000, 1'b0, 1,  0, 0, 1, 2'b11, 0,  0,  0,  3));

    run = 1'b1;
    @(negedge clk);
    check("first_imem_req", imem_req, 1);
    for (int i = 0; i < 2000 && prog.size() != 0; i++) @(negedge clk);
    check("prog_consumed", prog.size(), 0);
    run = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    @(negedge clk);
    check("stopped_idle", state, 0);
    check("retire_total", retire_cnt, 14);

    // run dropped while a store waits in MEM: store still retires, then IDLE
    prog.push_back(mk(15'b000000100000000, 1'b0, 1, 4, 1, 0, 2'b00, 0, 4, 4, 7));
    run = 1'b1;
    for (int i = 0; i < 200 && state != 3'd4; i++) @(negedge clk);
    check("reach_mem", state, 4);
    run = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("runstop_sb_drained", sb.size(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("runstop_idle", state, 0);
      check("runstop_no_fetch", imem_req, 0);
    end
    check("runstop_retire", retire_cnt, 15);

    // store with no ack: FAULT after TIMEOUT wait cycles, no retire
    saved_cnt = retire_cnt;
    tv = mk(15'b000000100000000, 1'b0, 1, 0, 1, 0, 2'b00, 0, TIMEOUT, TIMEOUT, 0);
    tv.retire = 1'b0;
    prog.push_back(tv);
    run = 1'b1;
    for (int i = 0; i < 200 && state != 3'd6; i++) @(negedge clk);
    check("reach_fault", state, 6);
    run = 1'b0;
    @(negedge clk);
    #1;
    check("fault_flag", fault, 1);
    check("fault_dwe_cycles", m_dwe, TIMEOUT);
    check("fault_dreq_cycles", m_dreq, TIMEOUT);
    check("fault_retire_hold", retire_cnt, saved_cnt);
    check("fault_other_outputs", {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc, pc_load, pc_sel}, 0);
    force_dack = 1'b1;
    @(negedge clk);
    force_dack = 1'b0;
    repeat (2) @(negedge clk);
    check("fault_ack_ignored_state", state, 6);
    check("fault_ack_ignored_flag", fault, 1);
    check("fault_ack_retire_hold", retire_cnt, saved_cnt);
    rst = 1'b1;
    #1;
    check("rst_clears_fault", fault, 0);
    check("rst_state", state, 0);
    check("rst_retire", retire_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
